// File: rtl/c499_key_sequencer_if.sv
// Word-side bus of the c499 key sequencer.
//   master : word source/sink (drives in_valid/in_data/in_chk/corr_en, out_ready)
//   slave  : the sequencer (drives in_ready, out_valid/out_data/out_mod)
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high; valid must not wait on ready, and the
// producer holds its payload stable while valid is high and ready is low.
interface c499_key_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8
);
  logic              corr_en;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_mod;

  modport master (
    output corr_en, in_valid, in_data, in_chk, out_ready,
    input  in_ready, out_valid, out_data, out_mod
  );

  modport slave (
    input  corr_en, in_valid, in_data, in_chk, out_ready,
    output in_ready, out_valid, out_data, out_mod
  );
endinterface

// File: rtl/c499_key_sequencer.sv
// Controller for a key-locked c499 32-bit SEC core.
// Loads the 19-bit unlock key serially (LSB = p1 first) and holds it, then
// pushes one data word at a time through the combinational core, registers
// the result and counts words the core modified.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_clear             drop key and any in-flight word, return to IDLE
//   key_valid/key_bit     serial key input; key_ready high in IDLE/LOAD
//   key_loaded, key_out   key status and key drive to the core p/X inputs
//   core_din/chk/en       registered drive to the core inputs
//   core_dout             core data outputs
//   err_cnt               saturating count of modified words
//   state_dbg             current FSM state (debug)
//   bus                   word in/out handshakes (slave side)
module c499_key_sequencer #(
  parameter int KEY_W  = 19,
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_clear,
  input  logic              key_valid,
  input  logic              key_bit,
  output logic              key_ready,
  output logic              key_loaded,
  output logic [KEY_W-1:0]  key_out,
  output logic [DATA_W-1:0] core_din,
  output logic [CHK_W-1:0]  core_chk,
  output logic              core_en,
  input  logic [DATA_W-1:0] core_dout,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [2:0]        state_dbg,
  c499_key_sequencer_if.slave bus
);

  localparam int BIT_W = $clog2(KEY_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARMED = 3'd2,
    S_EVAL  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_mod_q;
  logic              key_shift;
  logic              accept;
  logic              eval;
  logic              last_bit;
  logic              modified;

  assign last_bit = (bit_cnt_q == BIT_W'(KEY_W - 1));
  assign modified = (core_dout != shadow_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    key_shift = 1'b0;
    accept    = 1'b0;
    eval      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          key_shift = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (key_valid) begin
          key_shift = 1'b1;
          if (last_bit) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        eval    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear overrides everything, including a coincident key bit or accept.
    if (key_clear) begin
      state_d   = S_IDLE;
      key_shift = 1'b0;
      accept    = 1'b0;
      eval      = 1'b0;
    end
  end

  assign key_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign bus.in_ready  = (state_q == S_ARMED);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_mod   = out_mod_q;
  assign state_dbg     = state_q;

  // Key register: it is always zero when a load starts, so OR-ing the new
  // bit into its slot is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out    <= '0;
      key_loaded <= 1'b0;
      bit_cnt_q  <= '0;
    end else if (key_clear) begin
      key_out    <= '0;
      key_loaded <= 1'b0;
      bit_cnt_q  <= '0;
    end else if (key_shift) begin
      key_out   <= key_out | (KEY_W'(key_bit) << bit_cnt_q);
      bit_cnt_q <= bit_cnt_q + 1'b1;
      if (last_bit) key_loaded <= 1'b1;
    end
  end

  // Word path. The shadow copy of in_data lets the result be compared
  // against what was accepted, independent of later source activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_din   <= '0;
      core_chk   <= '0;
      core_en    <= 1'b0;
      shadow_q   <= '0;
      out_data_q <= '0;
      out_mod_q  <= 1'b0;
      err_cnt    <= '0;
    end else if (key_clear) begin
      core_en <= 1'b0;
    end else begin
      if (accept) begin
        core_din <= bus.in_data;
        core_chk <= bus.in_chk;
        core_en  <= bus.corr_en;
        shadow_q <= bus.in_data;
      end
      if (eval) begin
        out_data_q <= core_dout;
        out_mod_q  <= modified;
        if (modified && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c499_key_sequencer.sv
// Bench for c499_key_sequencer. The c499 core is modelled as data XOR a
// per-word flip mask; expected results come from the accepted word and that
// mask. The error counter is built 4 bits wide so saturation is reachable.
module tb_c499_key_sequencer;
  localparam int KEY_W  = 19;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              key_clear = 1'b0;
  logic              key_valid = 1'b0;
  logic              key_bit   = 1'b0;
  logic              key_ready;
  logic              key_loaded;
  logic [KEY_W-1:0]  key_out;
  logic [DATA_W-1:0] core_din;
  logic [CHK_W-1:0]  core_chk;
  logic              core_en;
  logic [DATA_W-1:0] core_dout;
  logic [CNT_W-1:0]  err_cnt;
  logic [2:0]        state_dbg;
  logic [DATA_W-1:0] flip_mask = '0;

  c499_key_sequencer_if #(.DATA_W(DATA_W), .CHK_W(CHK_W)) bus ();

  assign core_dout = core_din ^ flip_mask;

  c499_key_sequencer #(.KEY_W(KEY_W), .DATA_W(DATA_W), .CHK_W(CHK_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_clear  (key_clear),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_ready  (key_ready),
    .key_loaded (key_loaded),
    .key_out    (key_out),
    .core_din   (core_din),
    .core_chk   (core_chk),
    .core_en    (core_en),
    .core_dout  (core_dout),
    .err_cnt    (err_cnt),
    .state_dbg  (state_dbg),
    .bus        (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0]  exp_err = '0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k, input int nbits, input bit chk_prog);
    for (int i = 0; i < nbits; i++) begin
      repeat ($urandom_range(0, 2)) step();
      key_valid = 1'b1;
      key_bit   = k[i];
      step();
      key_valid = 1'b0;
      key_bit   = $urandom_range(0, 1);
      if (chk_prog && i == KEY_W - 2) begin
        check("key_loaded_early", key_loaded, 1'b0);
        check("in_ready_early", bus.in_ready, 1'b0);
      end
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic [CHK_W-1:0] c,
                           input logic en, input logic [DATA_W-1:0] flip, input int hold);
    int wait_n;
    logic [DATA_W-1:0] exp_d;
    logic exp_m;
    flip_mask   = flip;
    bus.in_data = d;
    bus.in_chk  = c;
    bus.corr_en = en;
    bus.in_valid = 1'b1;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 20) begin
      step();
      wait_n++;
    end
    check("in_ready_wait", bus.in_ready, 1'b1);
    exp_q.push_back(d ^ flip);
    step();  // accept edge
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_chk   = $urandom_range(0, 255);
    bus.corr_en  = ~en;
    check("core_din", core_din, d);
    check("core_chk", core_chk, c);
    check("core_en", core_en, en);
    check("out_valid_lat1", bus.out_valid, 1'b0);
    check("in_ready_eval", bus.in_ready, 1'b0);
    exp_d = exp_q.pop_front();
    exp_m = (flip != '0);
    if (exp_m && exp_err != CNT_MAX) exp_err = exp_err + 1'b1;
    step();
    check("out_valid_lat2", bus.out_valid, 1'b1);
    check("out_data", bus.out_data, exp_d);
    check("out_mod", bus.out_mod, exp_m);
    check("err_cnt", err_cnt, exp_err);
    check("in_ready_out", bus.in_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_data", bus.out_data, exp_d);
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 1'b0);
    check("in_ready_rearm", bus.in_ready, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [KEY_W-1:0] k1, k2, k3, k4;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_chk    = '0;
    bus.corr_en   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) step();
    check("rst_key_out", key_out, '0);
    check("rst_key_loaded", key_loaded, 1'b0);
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_core_en", core_en, 1'b0);
    check("rst_err_cnt", err_cnt, '0);
    rst_n = 1'b1;
    step();

    // key 1,0,1,1,0 repeating, with gaps
    for (int i = 0; i < KEY_W; i++) k1[i] = (i % 5 == 0) || (i % 5 == 2) || (i % 5 == 3);
    load_key(k1, KEY_W, 1'b1);
    check("key_loaded", key_loaded, 1'b1);
    check("key_out", key_out, k1);
    check("key_ready_low", key_ready, 1'b0);
    check("in_ready_armed", bus.in_ready, 1'b1);

    // key bits outside IDLE/LOAD are ignored
    key_valid = 1'b1;
    key_bit   = ~k1[0];
    repeat (2) step();
    key_valid = 1'b0;
    check("key_frozen", key_out, k1);

    // clean word, then single-bit flip
    send_word(32'h0000_0000, 8'h00, 1'b1, 32'h0, 0);
    send_word(32'h0000_0000, 8'h00, 1'b1, 32'h0000_0020, 0);
    // stalled sink
    send_word(32'hA5A5_5A5A, 8'h3C, 1'b1, 32'h0, 10);

    // random words
    for (int w = 0; w < 16; w++) begin
      logic [DATA_W-1:0] fl;
      fl = ($urandom_range(0, 3) != 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      send_word($urandom, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), fl,
                $urandom_range(0, 3));
    end
    // drive the counter to saturation and one past it
    for (int w = 0; w < 20 && exp_err != CNT_MAX; w++)
      send_word($urandom, 8'h11, 1'b1, 32'h8000_0000, 0);
    send_word($urandom, 8'h22, 1'b1, 32'h0000_0001, 0);
    check("err_sat", err_cnt, CNT_MAX);

    // key_clear in EVAL together with a key bit
    flip_mask    = 32'h0000_0100;
    bus.in_data  = 32'h1234_5678;
    bus.corr_en  = 1'b1;
    bus.in_valid = 1'b1;
    check("clr_pre_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check("clr_core_en_set", core_en, 1'b1);
    key_clear = 1'b1;
    key_valid = 1'b1;
    key_bit   = 1'b1;
    step();
    key_clear = 1'b0;
    key_valid = 1'b0;
    check("clr_key_out", key_out, '0);
    check("clr_key_loaded", key_loaded, 1'b0);
    check("clr_key_ready", key_ready, 1'b1);
    check("clr_in_ready", bus.in_ready, 1'b0);
    check("clr_core_en", core_en, 1'b0);
    check("clr_err_kept", err_cnt, exp_err);
    for (int i = 0; i < 3; i++) begin
      step();
      check("clr_no_out_valid", bus.out_valid, 1'b0);
    end
    k2 = KEY_W'($urandom);
    load_key(k2, KEY_W, 1'b1);
    check("reload_key_out", key_out, k2);
    check("reload_loaded", key_loaded, 1'b1);
    send_word(32'hDEAD_BEEF, 8'h5A, 1'b0, 32'h0, 1);

    // async reset in the middle of a load
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    k3 = {KEY_W{1'b1}};
    load_key(k3, 9, 1'b0);
    rst_n = 1'b0;
    #2;
    check("arst_key_out", key_out, '0);
    check("arst_key_loaded", key_loaded, 1'b0);
    check("arst_key_ready", key_ready, 1'b1);
    check("arst_in_ready", bus.in_ready, 1'b0);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_data", bus.out_data, '0);
    check("arst_err_cnt", err_cnt, '0);
    exp_err = '0;
    step();
    rst_n = 1'b1;
    step();
    k4 = KEY_W'($urandom);
    load_key(k4, KEY_W, 1'b1);
    check("arst_reload_key", key_out, k4);
    check("arst_reload_ready", bus.in_ready, 1'b1);
    send_word($urandom, 8'h77, 1'b1, 32'h0000_0004, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c499_key_sequencer.md
Name: c499_key_sequencer

Overview:
- Controller that owns a key-locked c499 32-bit SEC core: serially loads the 19-bit unlock key (4 mux-select bits p1..p4 and 15 XOR key bits X_1..X_15) and holds it stable.
- Sequences data words through the combinational core with valid/ready handshakes on both sides.
- Registers the core's output and counts words the core modified.
- Sits between the bus-side word source/sink and the locked c499 instance.

Parameters:
- KEY_W, 19, key length; key_out[3:0]=p1..p4, key_out[18:4]=X_1..X_15.
- DATA_W, 32, data word width (c499 data inputs N1..N125).
- CHK_W, 8, check-bit width (c499 N129..N136).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_clear  in  1  synchronous request to discard the key and reload.
- key_valid  in  1  serial key bit valid.
- key_bit  in  1  serial key bit, LSB (p1) first.
- key_ready  out  1  high in IDLE/LOAD.
- key_loaded  out  1  high once all KEY_W bits are held.
- key_out  out  KEY_W  key to the core's p/X inputs; changes only in LOAD.
- corr_en  in  1  correction enable, sampled at word accept.
- in_valid  in  1  source word valid.
- in_ready  out  1  word accepted when in_valid&&in_ready.
- in_data  in  DATA_W  data word.
- in_chk  in  CHK_W  check bits.
- core_din  out  DATA_W  registered drive to core N1..N125.
- core_chk  out  CHK_W  registered drive to core N129..N136.
- core_en  out  1  registered drive to core N137.
- core_dout  in  DATA_W  core outputs N724..N755.
- out_valid  out  1  result valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  registered result.
- out_mod  out  1  out_data differs from the accepted in_data.
- err_cnt  out  CNT_W  saturating count of modified words.

Behaviour:
- Reset (rst_n low, async): state IDLE; key_out=0, key_loaded=0, key_ready=1, in_ready=0, core_din/core_chk=0, core_en=0, out_valid=0, out_data=0, out_mod=0, err_cnt=0, bit counter=0.
- States: IDLE, LOAD, ARMED, EVAL, OUT.
- IDLE: the first key_valid shifts bit 0 and moves to LOAD with count=1.
- LOAD: each key_valid writes key_bit into key_out[count] and increments count. The write at count=KEY_W-1 sets key_loaded=1 and moves to ARMED next cycle. key_valid low means no change, with no timeout.
- key_valid outside IDLE/LOAD is ignored; key_out stays frozen.
- ARMED: in_ready=1. On accept:
  - core_din<=in_data, core_chk<=in_chk, core_en<=corr_en;
  - a shadow register keeps in_data;
  - state moves to EVAL.
- EVAL (one settle cycle for the combinational core):
  - out_data<=core_dout;
  - out_mod<=(core_dout!=shadow);
  - err_cnt increments when modified and saturates at all-ones;
  - state moves to OUT.
- OUT: out_valid=1. out_data and out_mod are held until out_ready. Completing the handshake moves to ARMED and drops out_valid next cycle.
- Timing: latency from accept edge to out_valid high is 2 cycles. Peak throughput is 1 word per 3 cycles. in_ready=0 in EVAL/OUT.
- key_clear, any state and highest priority, takes effect next edge:
  - state becomes IDLE; key_out=0, key_loaded=0, count=0;
  - out_valid=0 and any in-flight word is dropped;
  - core_en=0;
  - err_cnt is retained.
- key_clear together with key_valid: clear wins and the bit is discarded.
- key_clear together with a completing out handshake: clear wins, but the consumer already took the word.
- Async reset mid-operation: return to reset values immediately; no partial key survives.
- core_din, core_chk and core_en change only on an accept or on key_clear/reset.

Test Plan:
- Reset, then 19 key bits 1,0,1,1,0,… with key_valid gaps -> key_loaded rises the cycle after bit 18; key_out equals the shifted pattern; key_ready then low.
- Correct key, corr_en=1, in_data=0x0000_0000, chk=valid -> out_valid exactly 2 cycles after accept; out_data=0; out_mod=0; err_cnt unchanged.
- Core model flips bit 5 (out_data=0x0000_0020 vs in 0) -> out_mod=1; err_cnt 0->1. Preload err_cnt at 0xFFFF and repeat -> stays 0xFFFF.
- out_ready held low 10 cycles -> out_valid/out_data stable; in_ready=0 throughout; word accepted 1 cycle after out_ready handshake.
- key_clear asserted in EVAL while key_valid=1 -> next cycle IDLE, key_out=0, out_valid never asserts, bit ignored; reload works.
- rst_n pulsed low mid-LOAD (count=9) -> outputs immediately at reset values; a full 19-bit reload is then required before in_ready rises.
